// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Owns the single write port of the 8 x DATA_W register file. Three write-back
//   requesters (0 = ALU, 1 = load unit, 2 = move/immediate unit) are arbitrated
//   round-robin with valid/ready handshakes. The winner's address/data are
//   registered onto rf_we / rf_dst_add / rf_data_in, one cycle after the grant.
//   An 8-bit pending-write scoreboard lets the issue stage reserve destinations
//   and check two source addresses for outstanding writes.
//
// Optional feature (macro REGFILE_WB_FWD_EN):
//   Adds fwd_hit0/1 and fwd_data0/1 so a consumer can take the committing value
//   directly. chk_busyN is then masked by fwd_hitN, which removes the one-cycle
//   stall during the commit cycle.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is a one-hot grant)
//   req_addr, req_data    packed per-requester destination and data
//   wb_hold               blocks new grants for this cycle
//   rsv_valid/rsv_addr    destination reservation from issue; rsv_ready accepts
//   chk_addr0/1           source addresses; chk_busy0/1 flag pending writes
//   rf_we/rf_dst_add/rf_data_in   registered register-file write port
//   busy                  scoreboard bits
//   wb_err                sticky: write committed to an unreserved register
module regfile_wb_arbiter #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req_valid,
  output logic [2:0]            req_ready,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_data,
  input  logic                  wb_hold,
  input  logic                  rsv_valid,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  rsv_ready,
  input  logic [ADDR_W-1:0]     chk_addr0,
  input  logic [ADDR_W-1:0]     chk_addr1,
  output logic                  chk_busy0,
  output logic                  chk_busy1,
`ifdef REGFILE_WB_FWD_EN
  output logic                  fwd_hit0,
  output logic                  fwd_hit1,
  output logic [DATA_W-1:0]     fwd_data0,
  output logic [DATA_W-1:0]     fwd_data1,
`endif
  output logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_dst_add,
  output logic [DATA_W-1:0]     rf_data_in,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic                  wb_err
);

  localparam int NREG = 1 << ADDR_W;

  logic [1:0]        rr_ptr;
  logic [1:0]        win;
  logic              grant_en;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              rsv_fire;
  logic              commit_ok;
  logic              commit_bad;
  logic [NREG-1:0]   busy_nxt;

  // Winner search starts at rr_ptr; the illegal pointer value 3 behaves as 0.
  always_comb begin
    win = 2'd0;
    case (rr_ptr)
      2'd1:    win = req_valid[1] ? 2'd1 : (req_valid[2] ? 2'd2 : 2'd0);
      2'd2:    win = req_valid[2] ? 2'd2 : (req_valid[0] ? 2'd0 : 2'd1);
      default: win = req_valid[0] ? 2'd0 : (req_valid[1] ? 2'd1 : 2'd2);
    endcase
  end

  assign grant_en  = (|req_valid) & ~wb_hold;
  assign req_ready = grant_en ? (3'b001 << win) : 3'b000;

  always_comb begin
    win_addr = req_addr[ADDR_W-1:0];
    win_data = req_data[DATA_W-1:0];
    case (win)
      2'd1: begin
        win_addr = req_addr[ADDR_W +: ADDR_W];
        win_data = req_data[DATA_W +: DATA_W];
      end
      2'd2: begin
        win_addr = req_addr[2*ADDR_W +: ADDR_W];
        win_data = req_data[2*DATA_W +: DATA_W];
      end
      default: begin
        win_addr = req_addr[ADDR_W-1:0];
        win_data = req_data[DATA_W-1:0];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= 2'd0;
      rf_we      <= 1'b0;
      rf_dst_add <= '0;
      rf_data_in <= '0;
    end else begin
      rf_we <= grant_en;
      if (grant_en) begin
        rr_ptr     <= (win == 2'd2) ? 2'd0 : win + 2'd1;
        rf_dst_add <= win_addr;
        rf_data_in <= win_data;
      end
    end
  end

  // A reservation colliding with a commit to the same register is refused so
  // the clear wins; issue simply retries next cycle.
  assign rsv_ready  = ~busy[rsv_addr] & ~(rf_we & (rf_dst_add == rsv_addr));
  assign rsv_fire   = rsv_valid & rsv_ready;
  assign commit_ok  = rf_we &  busy[rf_dst_add];
  assign commit_bad = rf_we & ~busy[rf_dst_add];

  always_comb begin
    busy_nxt = busy;
    if (commit_ok) busy_nxt[rf_dst_add] = 1'b0;
    if (rsv_fire)  busy_nxt[rsv_addr]   = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= '0;
      wb_err <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (commit_bad) wb_err <= 1'b1;
    end
  end

`ifdef REGFILE_WB_FWD_EN
  assign fwd_hit0  = rf_we & (rf_dst_add == chk_addr0);
  assign fwd_hit1  = rf_we & (rf_dst_add == chk_addr1);
  assign fwd_data0 = rf_data_in;
  assign fwd_data1 = rf_data_in;
  assign chk_busy0 = busy[chk_addr0] & ~fwd_hit0;
  assign chk_busy1 = busy[chk_addr1] & ~fwd_hit1;
`else
  assign chk_busy0 = busy[chk_addr0];
  assign chk_busy1 = busy[chk_addr1];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 21;
  localparam int ADDR_W = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [2:0]           req_valid = '0;
  logic [2:0]           req_ready;
  logic [3*ADDR_W-1:0]  req_addr = '0;
  logic [3*DATA_W-1:0]  req_data = '0;
  logic                 wb_hold = 1'b0;
  logic                 rsv_valid = 1'b0;
  logic [ADDR_W-1:0]    rsv_addr = '0;
  logic                 rsv_ready;
  logic [ADDR_W-1:0]    chk_addr0 = '0;
  logic [ADDR_W-1:0]    chk_addr1 = '0;
  logic                 chk_busy0, chk_busy1;
  logic                 rf_we;
  logic [ADDR_W-1:0]    rf_dst_add;
  logic [DATA_W-1:0]    rf_data_in;
  logic [7:0]           busy;
  logic                 wb_err;
`ifdef REGFILE_WB_FWD_EN
  logic                 fwd_hit0, fwd_hit1;
  logic [DATA_W-1:0]    fwd_data0, fwd_data1;
`endif

  int checks = 0;
  int failures = 0;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .wb_hold(wb_hold),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .chk_addr0(chk_addr0), .chk_addr1(chk_addr1),
    .chk_busy0(chk_busy0), .chk_busy1(chk_busy1),
`ifdef REGFILE_WB_FWD_EN
    .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
    .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
`endif
    .rf_we(rf_we), .rf_dst_add(rf_dst_add), .rf_data_in(rf_data_in),
    .busy(busy), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0; rsv_valid = 1'b0; wb_hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0] valid;
    logic       hold;
    logic [2:0] exp_ready;
    logic       exp_we;
    logic [2:0] exp_dst;
  } vec_t;

  vec_t vecs[14];
  logic [DATA_W-1:0] bdata[4];
  logic [DATA_W-1:0] exp_data;

  initial begin
    // requester i writes address i+1 with data 0x100+i in the arbitration table
    vecs[0]  = '{3'b111, 1'b0, 3'b001, 1'b0, 3'd0};
    vecs[1]  = '{3'b111, 1'b0, 3'b010, 1'b1, 3'd1};
    vecs[2]  = '{3'b111, 1'b0, 3'b100, 1'b1, 3'd2};
    vecs[3]  = '{3'b111, 1'b0, 3'b001, 1'b1, 3'd3};
    vecs[4]  = '{3'b111, 1'b0, 3'b010, 1'b1, 3'd1};
    vecs[5]  = '{3'b111, 1'b0, 3'b100, 1'b1, 3'd2};
    vecs[6]  = '{3'b111, 1'b1, 3'b000, 1'b1, 3'd3};
    vecs[7]  = '{3'b000, 1'b0, 3'b000, 1'b0, 3'd3};
    vecs[8]  = '{3'b110, 1'b0, 3'b010, 1'b0, 3'd3};
    vecs[9]  = '{3'b011, 1'b0, 3'b001, 1'b1, 3'd2};
    vecs[10] = '{3'b101, 1'b0, 3'b100, 1'b1, 3'd1};
    vecs[11] = '{3'b100, 1'b0, 3'b100, 1'b1, 3'd3};
    vecs[12] = '{3'b010, 1'b1, 3'b000, 1'b1, 3'd3};
    vecs[13] = '{3'b000, 1'b0, 3'b000, 1'b0, 3'd3};
    bdata[0] = 21'h1FFFFF; bdata[1] = 21'h000000;
    bdata[2] = 21'h0AAAAA; bdata[3] = 21'h155555;

    // reset state
    @(negedge clk);
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_dst", rf_dst_add, 0);
    chk("rst_data", rf_data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", wb_err, 0);
    chk("rst_ptr", dut.rr_ptr, 0);
    chk("rst_ready", req_ready, 0);
    rst = 1'b0;

    // round-robin table
    for (int i = 0; i < 3; i++) begin
      req_addr[ADDR_W*i +: ADDR_W] = 3'(i + 1);
      req_data[DATA_W*i +: DATA_W] = 21'h100 + 21'(i);
    end
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      req_valid = vecs[v].valid;
      wb_hold   = vecs[v].hold;
      #1;
      exp_data = (vecs[v].exp_dst == 3'd0) ? 21'h0 : 21'h100 + 21'(vecs[v].exp_dst) - 21'h1;
      chk($sformatf("rr_ready[%0d]", v), req_ready, vecs[v].exp_ready);
      chk($sformatf("rr_we[%0d]", v), rf_we, vecs[v].exp_we);
      chk($sformatf("rr_dst[%0d]", v), rf_dst_add, vecs[v].exp_dst);
      chk($sformatf("rr_data[%0d]", v), rf_data_in, exp_data);
    end

    // back-to-back single requester (load unit)
    req_addr[ADDR_W +: ADDR_W] = 3'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 3'b010;
      wb_hold = 1'b0;
      req_data[DATA_W +: DATA_W] = bdata[i];
      #1;
      chk($sformatf("b2b_ready[%0d]", i), req_ready, 3'b010);
      if (i > 0) begin
        chk($sformatf("b2b_we[%0d]", i), rf_we, 1);
        chk($sformatf("b2b_data[%0d]", i), rf_data_in, bdata[i-1]);
      end
    end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    chk("b2b_last_we", rf_we, 1);
    chk("b2b_last_data", rf_data_in, bdata[3]);
    chk("b2b_ptr", dut.rr_ptr, 2);

    // scoreboard
    do_reset();
    rsv_valid = 1'b1; rsv_addr = 3'd5; chk_addr0 = 3'd5; chk_addr1 = 3'd5;
    #1;
    chk("sb_rsv_ready_a", rsv_ready, 1);
    chk("sb_chk0_free", chk_busy0, 0);
    @(negedge clk);
    req_valid = 3'b001; req_addr[2:0] = 3'd5; req_data[DATA_W-1:0] = 21'h0ABCDE;
    #1;
    chk("sb_busy_r5", busy, 8'h20);
    chk("sb_chk0_busy", chk_busy0, 1);
    chk("sb_rsv_dup", rsv_ready, 0);
    chk("sb_alu_ready", req_ready, 3'b001);
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    chk("sb_commit_we", rf_we, 1);
    chk("sb_commit_dst", rf_dst_add, 5);
    chk("sb_rsv_commit", rsv_ready, 0);
`ifdef REGFILE_WB_FWD_EN
    chk("fwd_hit1", fwd_hit1, 1);
    chk("fwd_data1", fwd_data1, 21'h0ABCDE);
    chk("fwd_chk1", chk_busy1, 0);
    chk("fwd_chk0", chk_busy0, 0);
`else
    chk("nofwd_chk1", chk_busy1, 1);
    chk("nofwd_chk0", chk_busy0, 1);
`endif
    @(negedge clk);
    rsv_addr = 3'd6;
    req_valid = 3'b001; req_addr[2:0] = 3'd6;
    #1;
    chk("sb_cleared", busy, 8'h00);
    chk("sb_err_clean", wb_err, 0);
    chk("sb_rsv6_ready", rsv_ready, 1);
    @(negedge clk);
    req_valid = 3'b000; rsv_addr = 3'd2;
    #1;
    chk("sb_busy_r6", busy, 8'h40);
    chk("sb_commit6", rf_dst_add, 6);
    chk("sb_rsv2_ready", rsv_ready, 1);
    @(negedge clk);
    rsv_valid = 1'b0;
    #1;
    chk("sb_set_and_clear", busy, 8'h04);
    chk("sb_err_still0", wb_err, 0);

    // unreserved write -> sticky error
    do_reset();
    req_valid = 3'b100; req_addr[2*ADDR_W +: ADDR_W] = 3'd3;
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    chk("err_commit_we", rf_we, 1);
    chk("err_pre", wb_err, 0);
    @(negedge clk);
    rsv_valid = 1'b1; rsv_addr = 3'd1;
    req_valid = 3'b001; req_addr[2:0] = 3'd1;
    #1;
    chk("err_set", wb_err, 1);
    chk("err_busy_unchanged", busy, 8'h00);
    @(negedge clk);
    rsv_valid = 1'b0; req_valid = 3'b000;
    @(negedge clk);
    #1;
    chk("err_legal_busy", busy, 8'h00);
    chk("err_sticky", wb_err, 1);
    do_reset();
    #1;
    chk("err_cleared", wb_err, 0);

    // asynchronous reset with a write in flight
    rsv_valid = 1'b1; rsv_addr = 3'd4;
    req_valid = 3'b010; req_addr[ADDR_W +: ADDR_W] = 3'd4;
    @(negedge clk);
    rsv_valid = 1'b0;
    #1;
    chk("ar_pre_we", rf_we, 1);
    chk("ar_pre_ptr", dut.rr_ptr, 2);
    chk("ar_pre_busy", busy, 8'h10);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_we", rf_we, 0);
    chk("ar_busy", busy, 8'h00);
    chk("ar_ptr", dut.rr_ptr, 0);
    @(negedge clk);
    rst = 1'b0; req_valid = 3'b000;
    #1;
    chk("ar_no_write", rf_we, 0);
    chk("ar_no_err", wb_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
